reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port reg_read_en  input  1  port A (fetch) read request, sampled on clk.
REQ-004 SHALL have port reg_read_reg  input  4  port A read index R0..R15.
REQ-005 SHALL have port reg_read_value  output  32  port A registered read data.
REQ-006 SHALL have port reg_write_en  input  1  port A write request.
REQ-007 SHALL have port reg_write_reg  input  4  port A write index.
REQ-008 SHALL have port reg_write_value  input  32  port A write data.
REQ-009 SHALL have port reg_write_restore_from_SPSR  input  1  port A write also copies SPSR into CPSR.
REQ-010 SHALL have ports ex_read_en/ex_read_reg/ex_read_value  in/in/out  1/4/32  port B (execute) read, same semantics as port A.
REQ-011 SHALL have ports ex_write_en/ex_write_reg/ex_write_value/ex_write_restore_from_SPSR  in  1/4/32/1  port B write, same semantics as port A.
REQ-012 SHALL have ports cpsr_write_en/cpsr_write_value  in  1/32  direct CPSR update (flags, mode).
REQ-013 SHALL have ports spsr_write_en/spsr_write_value  in  1/32  direct SPSR update.
REQ-014 SHALL have ports cpsr/spsr  out  32/32  current status registers, driven straight from state.

Function
REQ-015 SHALL hold 16 x 32-bit GPRs; R15 is PC, stored as written, no implicit increment or alignment.
REQ-016 Read: read_en high at edge N SHALL load read_value with selected register at edge N; value SHALL hold until next read_en on that port (one-cycle latency, stable while en low).
REQ-017 Write: write_en high at edge N SHALL update the register at edge N; reads at N+1 onward see new value.
REQ-018 Same-edge read and write of same register SHALL return the write data (write-first bypass), B data if both ports write it.
REQ-019 Both ports writing same register at same edge SHALL commit port B value (execute branch target beats fetch PC+4); different registers SHALL both commit.
REQ-020 Restore: write_en and restore_from_SPSR high SHALL set CPSR <= SPSR at same edge as the register write; restore with write_en low SHALL be ignored.
REQ-021 CPSR priority at one edge: restore (either port) > cpsr_write_en; SPSR value used by restore SHALL be pre-edge value even if spsr_write_en is high same edge.
REQ-022 spsr_write_en SHALL update SPSR at the edge; no other source modifies SPSR.
REQ-023 Read of index not requested (en low) SHALL never change read_value; no X propagation on any output.

Reset
REQ-024 rst_n low SHALL immediately clear R0..R15, SPSR, reg_read_value, ex_read_value to 0 and set CPSR to 32'h0000_00D3 (SVC, IRQ/FIQ masked).
REQ-025 Reset asserted mid-request SHALL discard the pending read/write; first request after rst_n rises SHALL behave as REQ-016/017.

Configuration
REQ-026 Macro REG_BANK_PSR_EN: defined -> CPSR/SPSR state, restore, cpsr/spsr write ports as above; undefined -> no PSR storage, cpsr output constant 32'h0000_00D3, spsr output 0, restore and PSR write inputs ignored, GPR behaviour unchanged.

Structure
REQ-027 Shared package SHALL hold register index constants (REG_PC=15, REG_LR=14, REG_SP=13), CPSR reset constant, CPSR mode/flag bit positions.
REQ-028 SHALL be one flat module; no sub-module.

Verification
REQ-029 Reset, then port A read R15 -> reg_read_value 0 one edge later; cpsr 32'h0000_00D3.
REQ-030 Port A write R3=32'hDEAD_BEEF, next edge read R3 -> 32'hDEAD_BEEF; same-edge write R4=5 and read R4 -> 5.
REQ-031 Same edge A writes R15=32'h104, B writes R15=32'h200 -> R15 reads 32'h200.
REQ-032 spsr_write 32'h0000_0010, then A writes R15=32'h18 with restore -> cpsr 32'h0000_0010, R15 32'h18; same-edge cpsr_write 32'hF000_0000 loses.
REQ-033 rst_n low while reg_write_en high for R1=7 -> R1 reads 0 after release; reg_read_value holds across en-low cycles.
REQ-034 Build without REG_BANK_PSR_EN, restore write -> cpsr stays 32'h0000_00D3, GPR write still commits.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for reg_bank: widths, architectural register indices,
// CPSR reset value, and CPSR mode/flag bit positions.
package reg_bank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_REGS = 16;

  localparam logic [IDX_W-1:0] REG_SP = IDX_W'(13);
  localparam logic [IDX_W-1:0] REG_LR = IDX_W'(14);
  localparam logic [IDX_W-1:0] REG_PC = IDX_W'(15);

  // SVC mode with IRQ and FIQ masked
  localparam logic [DATA_W-1:0] CPSR_RESET = 32'h0000_00D3;

  localparam int unsigned CPSR_N_BIT    = 31;
  localparam int unsigned CPSR_Z_BIT    = 30;
  localparam int unsigned CPSR_C_BIT    = 29;
  localparam int unsigned CPSR_V_BIT    = 28;
  localparam int unsigned CPSR_I_BIT    = 7;
  localparam int unsigned CPSR_F_BIT    = 6;
  localparam int unsigned CPSR_T_BIT    = 5;
  localparam int unsigned CPSR_MODE_LSB = 0;
  localparam int unsigned CPSR_MODE_W   = 5;

  typedef enum logic [CPSR_MODE_W-1:0] {
    MODE_USR = 5'h10,
    MODE_FIQ = 5'h11,
    MODE_IRQ = 5'h12,
    MODE_SVC = 5'h13,
    MODE_ABT = 5'h17,
    MODE_UND = 5'h1B,
    MODE_SYS = 5'h1F
  } cpu_mode_e;

  function automatic cpu_mode_e cpsr_mode(input logic [DATA_W-1:0] psr);
    return cpu_mode_e'(psr[CPSR_MODE_LSB +: CPSR_MODE_W]);
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Dual-port (fetch A / execute B) 16x32 register file with CPSR/SPSR.
// PSR storage, restore and PSR write ports exist only when REG_BANK_PSR_EN is defined.
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_read_en,
  input  logic [IDX_W-1:0]  reg_read_reg,
  output logic [DATA_W-1:0] reg_read_value,
  input  logic              reg_write_en,
  input  logic [IDX_W-1:0]  reg_write_reg,
  input  logic [DATA_W-1:0] reg_write_value,
  input  logic              reg_write_restore_from_SPSR,
  input  logic              ex_read_en,
  input  logic [IDX_W-1:0]  ex_read_reg,
  output logic [DATA_W-1:0] ex_read_value,
  input  logic              ex_write_en,
  input  logic [IDX_W-1:0]  ex_write_reg,
  input  logic [DATA_W-1:0] ex_write_value,
  input  logic              ex_write_restore_from_SPSR,
  input  logic              cpsr_write_en,
  input  logic [DATA_W-1:0] cpsr_write_value,
  input  logic              spsr_write_en,
  input  logic [DATA_W-1:0] spsr_write_value,
  output logic [DATA_W-1:0] cpsr,
  output logic [DATA_W-1:0] spsr
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  // Port B applied after port A so it wins a same-register collision
  always_comb begin
    gpr_d = gpr_q;
    if (reg_write_en) gpr_d[reg_write_reg] = reg_write_value;
    if (ex_write_en)  gpr_d[ex_write_reg]  = ex_write_value;
  end

  // Reads index the post-write image, giving write-first bypass
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (reg_read_en) rd_a_d = gpr_d[reg_read_reg];
    if (ex_read_en)  rd_b_d = gpr_d[ex_read_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) gpr_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      gpr_q  <= gpr_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign reg_read_value = rd_a_q;
  assign ex_read_value  = rd_b_q;

`ifdef REG_BANK_PSR_EN
  logic [DATA_W-1:0] cpsr_q, cpsr_d;
  logic [DATA_W-1:0] spsr_q, spsr_d;
  logic              restore_c;

  assign restore_c = (reg_write_en & reg_write_restore_from_SPSR)
                   | (ex_write_en  & ex_write_restore_from_SPSR);

  // Restore uses the pre-edge SPSR and overrides a direct CPSR write
  always_comb begin
    cpsr_d = cpsr_q;
    spsr_d = spsr_q;
    if (cpsr_write_en) cpsr_d = cpsr_write_value;
    if (restore_c)     cpsr_d = spsr_q;
    if (spsr_write_en) spsr_d = spsr_write_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q <= CPSR_RESET;
      spsr_q <= '0;
    end else begin
      cpsr_q <= cpsr_d;
      spsr_q <= spsr_d;
    end
  end

  assign cpsr = cpsr_q;
  assign spsr = spsr_q;
`else
  logic unused_psr;

  assign unused_psr = ^{reg_write_restore_from_SPSR, ex_write_restore_from_SPSR,
                        cpsr_write_en, cpsr_write_value,
                        spsr_write_en, spsr_write_value};

  assign cpsr = CPSR_RESET;
  assign spsr = '0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// against an array-based reference model. Follows REG_BANK_PSR_EN like the RTL.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_read_en, reg_write_en, reg_write_restore_from_SPSR;
  logic [3:0]  reg_read_reg, reg_write_reg;
  logic [31:0] reg_write_value, reg_read_value;
  logic        ex_read_en, ex_write_en, ex_write_restore_from_SPSR;
  logic [3:0]  ex_read_reg, ex_write_reg;
  logic [31:0] ex_write_value, ex_read_value;
  logic        cpsr_write_en, spsr_write_en;
  logic [31:0] cpsr_write_value, spsr_write_value, cpsr, spsr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_gpr [16];
  logic [31:0] m_rda, m_rdb, m_cpsr, m_spsr;

  reg_bank dut (
    .clk(clk), .rst_n(rst_n),
    .reg_read_en(reg_read_en), .reg_read_reg(reg_read_reg), .reg_read_value(reg_read_value),
    .reg_write_en(reg_write_en), .reg_write_reg(reg_write_reg),
    .reg_write_value(reg_write_value), .reg_write_restore_from_SPSR(reg_write_restore_from_SPSR),
    .ex_read_en(ex_read_en), .ex_read_reg(ex_read_reg), .ex_read_value(ex_read_value),
    .ex_write_en(ex_write_en), .ex_write_reg(ex_write_reg),
    .ex_write_value(ex_write_value), .ex_write_restore_from_SPSR(ex_write_restore_from_SPSR),
    .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
    .spsr_write_en(spsr_write_en), .spsr_write_value(spsr_write_value),
    .cpsr(cpsr), .spsr(spsr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reg_read_en = 0; reg_write_en = 0; reg_write_restore_from_SPSR = 0;
    ex_read_en = 0;  ex_write_en = 0;  ex_write_restore_from_SPSR = 0;
    cpsr_write_en = 0; spsr_write_en = 0;
  endtask

  task automatic model_reset();
    foreach (m_gpr[i]) m_gpr[i] = '0;
    m_rda = '0; m_rdb = '0; m_spsr = '0; m_cpsr = 32'h0000_00D3;
  endtask

  // Reference behaviour for one rising edge given the currently driven inputs
  task automatic model_edge();
    logic [31:0] nxt [16];
    bit restore;
    nxt = m_gpr;
    if (reg_write_en) nxt[reg_write_reg] = reg_write_value;
    if (ex_write_en)  nxt[ex_write_reg]  = ex_write_value;
    if (reg_read_en)  m_rda = nxt[reg_read_reg];
    if (ex_read_en)   m_rdb = nxt[ex_read_reg];
`ifdef REG_BANK_PSR_EN
    restore = (reg_write_en && reg_write_restore_from_SPSR) ||
              (ex_write_en && ex_write_restore_from_SPSR);
    if (restore)            m_cpsr = m_spsr;
    else if (cpsr_write_en) m_cpsr = cpsr_write_value;
    if (spsr_write_en)      m_spsr = spsr_write_value;
`else
    restore = 0;
`endif
    m_gpr = nxt;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdA"}, reg_read_value, m_rda);
    check({tag, ".rdB"}, ex_read_value, m_rdb);
    check({tag, ".cpsr"}, cpsr, m_cpsr);
    check({tag, ".spsr"}, spsr, m_spsr);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    idle();
    reg_read_reg = 0; reg_write_reg = 0; reg_write_value = 0;
    ex_read_reg = 0;  ex_write_reg = 0;  ex_write_value = 0;
    cpsr_write_value = 0; spsr_write_value = 0;
    rst_n = 0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // Read PC after reset
    reg_read_en = 1; reg_read_reg = REG_PC;
    tick("rd_pc");
    check("rd_pc_lit", reg_read_value, 32'h0);
    check("cpsr_rst_lit", cpsr, 32'h0000_00D3);
    idle();

    // Write then read, and same-edge bypass
    reg_write_en = 1; reg_write_reg = 3; reg_write_value = 32'hDEAD_BEEF;
    tick("wr_r3");
    idle();
    reg_read_en = 1; reg_read_reg = 3;
    tick("rd_r3");
    check("rd_r3_lit", reg_read_value, 32'hDEAD_BEEF);
    reg_write_en = 1; reg_write_reg = 4; reg_write_value = 32'd5;
    reg_read_en = 1;  reg_read_reg = 4;
    tick("bypass_r4");
    check("bypass_r4_lit", reg_read_value, 32'd5);
    idle();

    // Dual write to PC: B wins, and same-edge read sees B data
    reg_write_en = 1; reg_write_reg = REG_PC; reg_write_value = 32'h104;
    ex_write_en = 1;  ex_write_reg = REG_PC;  ex_write_value = 32'h200;
    reg_read_en = 1;  reg_read_reg = REG_PC;
    tick("dual_wr_pc");
    check("dual_bypass_lit", reg_read_value, 32'h200);
    idle();
    ex_read_en = 1; ex_read_reg = REG_PC;
    tick("rd_pc_b");
    check("dual_pc_lit", ex_read_value, 32'h200);
    idle();

    // SPSR restore beats a same-edge CPSR write
    spsr_write_en = 1; spsr_write_value = 32'h0000_0010;
    tick("spsr_wr");
    idle();
    reg_write_en = 1; reg_write_reg = REG_PC; reg_write_value = 32'h18;
    reg_write_restore_from_SPSR = 1;
    cpsr_write_en = 1; cpsr_write_value = 32'hF000_0000;
    spsr_write_en = 1; spsr_write_value = 32'h0000_001F;
    tick("restore");
`ifdef REG_BANK_PSR_EN
    check("restore_cpsr_lit", cpsr, 32'h0000_0010);
`else
    check("restore_cpsr_lit", cpsr, 32'h0000_00D3);
`endif
    idle();
    reg_read_en = 1; reg_read_reg = REG_PC;
    tick("rd_pc_restore");
    check("restore_pc_lit", reg_read_value, 32'h18);
    idle();

    // Restore flag with write_en low is ignored
    ex_write_restore_from_SPSR = 1; reg_write_restore_from_SPSR = 1;
    tick("restore_noen");
    idle();

    // Read value holds across enable-low cycles
    reg_write_en = 1; reg_write_reg = 3; reg_write_value = 32'h1234_5678;
    tick("wr_r3_hold");
    idle();
    reg_read_reg = 3;
    tick("hold1");
    tick("hold2");
    check("hold_lit", reg_read_value, 32'h18);

    // Asynchronous reset during a pending write of R1
    reg_write_en = 1; reg_write_reg = 1; reg_write_value = 32'd7;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("in_rst");
    idle();
    rst_n = 1;
    reg_read_en = 1; reg_read_reg = 1;
    tick("rd_r1_after_rst");
    check("r1_after_rst_lit", reg_read_value, 32'h0);
    idle();

    // Randomized traffic, biased toward a few registers to force collisions
    for (int n = 0; n < 600; n++) begin
      reg_read_en  = 1'($urandom);
      ex_read_en   = 1'($urandom);
      reg_write_en = 1'($urandom);
      ex_write_en  = 1'($urandom);
      reg_read_reg  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      ex_read_reg   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      reg_write_reg = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      ex_write_reg  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      reg_write_value = $urandom;
      ex_write_value  = $urandom;
      reg_write_restore_from_SPSR = ($urandom_range(0, 7) == 0);
      ex_write_restore_from_SPSR  = ($urandom_range(0, 7) == 0);
      cpsr_write_en = ($urandom_range(0, 3) == 0);
      spsr_write_en = ($urandom_range(0, 3) == 0);
      cpsr_write_value = $urandom;
      spsr_write_value = $urandom;
      tick("rand");
    end
    idle();

    // Sweep all registers back through both ports
    for (int r = 0; r < 16; r++) begin
      reg_read_en = 1; reg_read_reg = 4'(r);
      ex_read_en = 1;  ex_read_reg = 4'(15 - r);
      tick("sweep");
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
